pattern_reader: RTL and testbench
=================================

Name: pattern_reader

Overview:
- Initiator side of the combinational bit-pattern ROM interface.
- Drives the ROM address port (1-based, default entries read 0) and samples the 1-bit data return.
- Presents the fetched bits as a serial stream with a valid/ready handshake, for feeding the Moore sequence detector under test.
- Supports programmable length, loop mode, abort, and a running count of ones streamed.

Parameters:
- ADDR_W, 1024, width of the ROM address port; upper bits beyond LEN_W are driven 0.
- LEN_W, 8, width of the length input and the internal index/ones counters.
- BASE_ADDR, 1, ROM address of the first pattern bit.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a run when in IDLE, ignored otherwise.
- len  input  LEN_W  number of bits per run; sampled on accepted start.
- loop  input  1  when 1, restart from BASE_ADDR after the last bit; sampled on accepted start.
- abort  input  1  terminates a run; returns to IDLE.
- mem_addr  output  ADDR_W  address to ROM.
- mem_data  input  1  ROM data; combinational response to mem_addr.
- bit_out  output  1  current stream bit.
- bit_valid  output  1  bit_out is valid.
- bit_ready  input  1  consumer accepts bit_out when bit_valid && bit_ready.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse after the last bit of a pass is accepted.
- ones_count  output  LEN_W  number of accepted 1-bits since the last start; wraps modulo 2^LEN_W.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - mem_addr = 0, bit_valid = 0.
  - start with len != 0: latch len and loop, clear idx and ones_count, go to FETCH.
  - start with len == 0: assert done for one cycle, stay in IDLE, clear ones_count.
- FETCH:
  - mem_addr = BASE_ADDR + idx, zero-extended to ADDR_W.
  - Register mem_data into bit_out at the clock edge; go to HOLD.
  - bit_valid is 0 throughout FETCH.
- HOLD:
  - bit_valid = 1; bit_out and mem_addr are held stable until accepted.
  - On accept, ones_count increments by bit_out.
  - If idx == len_q - 1, go to DONE; otherwise idx++ and go to FETCH.
  - No accept: remain in HOLD indefinitely.
- DONE:
  - done = 1 for exactly this cycle; bit_valid = 0.
  - loop_q = 1: clear idx, go to FETCH; ones_count keeps accumulating.
  - loop_q = 0: go to IDLE.
- Timing:
  - Start accepted at edge N → first bit_valid in cycle N+2.
  - Maximum throughput is one bit per 2 cycles.
- abort:
  - Any state except IDLE: next state IDLE and bit_valid drops at the next edge.
  - No done pulse. ones_count holds its value.
  - abort in the same cycle as an accept: the accept counts, then go to IDLE.
  - abort together with start in IDLE: start wins.
- start while busy is ignored, except that an asserted start in DONE with loop_q = 0 is not accepted; a new start is taken only in IDLE.
- len and loop changes after an accepted start have no effect until the next start.
- Reset mid-run: immediate return to reset values; no done pulse.
- idx and len_q are LEN_W bits wide; len = 2^LEN_W − 1 is the maximum run length.

Decomposition:
- Shared package pattern_pkg holds the state enum (IDLE, FETCH, HOLD, DONE) and the BASE_ADDR default constant.
- One sub-module is natural: pattern_rd_ctr, holding the idx/ones counters with clear, increment, and terminal-count compare.
- The FSM stays in pattern_reader.

Test Plan:
- Basic run:
  - Stimulus: ROM model with addr1..21 = 1,0,0,0,1,1,0,0,0,1,0,1,1,0,1,0,0,0,1,0,0; len=21, loop=0, bit_ready tied 1, pulse start.
  - Response: 21 accepted bits in that exact order, first bit_valid 2 cycles after start, one done pulse, ones_count = 8, mem_addr sequence 1..21, then IDLE with busy = 0.
- Backpressure:
  - Stimulus: len=5; bit_ready low for 3 cycles on each bit.
  - Response: bit_out and mem_addr stable while valid and not ready; bits 1,0,0,0,1; ones_count = 2.
- Loop:
  - Stimulus: len=3, loop=1, ready=1, run for 3 passes.
  - Response: pattern 1,0,0 repeats; done pulses once per pass; ones_count = 3; mem_addr wraps 3 → 1.
- Abort:
  - Stimulus: len=21; abort asserted while in HOLD of bit 6, coincident with accept.
  - Response: bit 6 is counted, ones_count = 3, IDLE next cycle, no done pulse.
- Zero length and ignored start:
  - Stimulus: start with len=0, then a second start asserted during a len=4 run.
  - Response: len=0 gives a single-cycle done with busy = 0 and no bit_valid; the second start has no effect and the len=4 run completes normally.
- Async reset:
  - Stimulus: assert reset mid-HOLD, between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg
// Shared definitions for the pattern reader slice.
//   state_t       : reader FSM states (IDLE, FETCH, HOLD, DONE)
//   BASE_ADDR_DEF : default ROM address of the first pattern bit
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BASE_ADDR_DEF = 1;

endpackage

// File: rtl/pattern_if.sv
// pattern_if
// Bundles the ROM address/data bus and the serial bit stream handshake.
//   mem_addr  : address to the ROM (initiator -> ROM)
//   mem_data  : combinational 1-bit ROM response (ROM -> initiator)
//   bit_out   : current stream bit (initiator -> consumer)
//   bit_valid : bit_out is valid (initiator -> consumer)
//   bit_ready : consumer accepts bit_out (consumer -> initiator)
// master = reader side, slave = ROM/consumer side.
interface pattern_if #(
    parameter int ADDR_W = 1024
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data;
    logic              bit_out;
    logic              bit_valid;
    logic              bit_ready;

    modport master (
        output mem_addr,
        input  mem_data,
        output bit_out,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  bit_out,
        input  bit_valid,
        output bit_ready
    );

endinterface

// File: rtl/pattern_rd_ctr.sv
// pattern_rd_ctr
// Bit index and ones counters for the pattern reader.
//   i_clk, i_reset : clock, async active-high reset
//   i_clrIdx       : clear the bit index (has priority over increment)
//   i_incIdx       : advance the bit index
//   i_clrOnes      : clear the ones counter (has priority over add)
//   i_addOne       : count one accepted 1-bit
//   i_lenQ         : latched run length
//   o_idx          : current bit index within the pass
//   o_ones         : accepted ones since last start, wraps
//   o_lastIdx      : index points at the final bit of the pass
module pattern_rd_ctr #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clrIdx,
    input  logic             i_incIdx,
    input  logic             i_clrOnes,
    input  logic             i_addOne,
    input  logic [LEN_W-1:0] i_lenQ,
    output logic [LEN_W-1:0] o_idx,
    output logic [LEN_W-1:0] o_ones,
    output logic             o_lastIdx
);

    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] r_ones;

    // Position of the bit currently being fetched/held inside one pass.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= '0;
        end else if (i_clrIdx) begin
            r_idx <= '0;
        end else if (i_incIdx) begin
            r_idx <= r_idx + LEN_W'(1);
        end
    end

    // Running count of accepted ones; natural wrap at 2^LEN_W.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ones <= '0;
        end else if (i_clrOnes) begin
            r_ones <= '0;
        end else if (i_addOne) begin
            r_ones <= r_ones + LEN_W'(1);
        end
    end

    assign o_idx     = r_idx;
    assign o_ones    = r_ones;
    // len_q is never 0 while a run is active, so len_q-1 never underflows there.
    assign o_lastIdx = (r_idx == (i_lenQ - LEN_W'(1)));

endmodule

// File: rtl/pattern_reader.sv
// pattern_reader
// Reads a bit pattern from a combinational ROM and streams it out with a
// valid/ready handshake. Supports programmable length, loop mode and abort.
//   i_clk, i_reset : clock, async active-high reset
//   i_start        : start pulse, accepted only in IDLE
//   i_len          : bits per pass, sampled on accepted start
//   i_loop         : repeat passes, sampled on accepted start
//   i_abort        : end the run immediately (no done pulse)
//   bus            : ROM bus + bit stream (master side)
//   o_busy         : not in IDLE
//   o_done         : one-cycle pulse after the last bit of a pass
//   o_onesCount    : accepted ones since the last start
module pattern_reader
    import pattern_pkg::*;
#(
    parameter int ADDR_W    = 1024,
    parameter int LEN_W     = 8,
    parameter int BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_loop,
    input  logic             i_abort,
    pattern_if.master        bus,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_onesCount
);

    localparam logic [ADDR_W-1:0] BaseAddrW = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    logic [LEN_W-1:0]  r_lenQ;
    logic              r_loopQ;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_bitOut;
    logic              r_bitValid;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_clrIdx;
    logic              w_incIdx;
    logic              w_clrOnes;
    logic              w_addOne;
    logic [LEN_W-1:0]  w_idx;
    logic [LEN_W-1:0]  w_ones;
    logic              w_lastIdx;

    // bit_valid is only ever high in HOLD, so HOLD && ready is the handshake.
    assign w_accept  = (r_state == HOLD) && bus.bit_ready;
    assign w_clrIdx  = ((r_state == IDLE) && i_start) || (r_state == DONE);
    assign w_incIdx  = w_accept && !w_lastIdx;
    assign w_clrOnes = (r_state == IDLE) && i_start;
    // An accept coincident with abort still counts.
    assign w_addOne  = w_accept && r_bitOut;

    pattern_rd_ctr #(
        .LEN_W(LEN_W)
    ) u_ctr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clrIdx (w_clrIdx),
        .i_incIdx (w_incIdx),
        .i_clrOnes(w_clrOnes),
        .i_addOne (w_addOne),
        .i_lenQ   (r_lenQ),
        .o_idx    (w_idx),
        .o_ones   (w_ones),
        .o_lastIdx(w_lastIdx)
    );

    // Main FSM. mem_addr is registered and loaded one edge ahead so the ROM
    // sees the right address for the whole FETCH cycle and holds through HOLD.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_lenQ     <= '0;
            r_loopQ    <= 1'b0;
            r_memAddr  <= '0;
            r_bitOut   <= 1'b0;
            r_bitValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_lenQ    <= i_len;
                            r_loopQ   <= i_loop;
                            r_memAddr <= BaseAddrW;
                            r_busy    <= 1'b1;
                            r_state   <= FETCH;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (i_abort) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_memAddr <= '0;
                    end else begin
                        r_bitOut   <= bus.mem_data;
                        r_bitValid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_abort) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_bitValid <= 1'b0;
                        r_memAddr  <= '0;
                    end else if (w_accept) begin
                        r_bitValid <= 1'b0;
                        if (w_lastIdx) begin
                            r_done    <= 1'b1;
                            r_memAddr <= '0;
                            r_state   <= DONE;
                        end else begin
                            r_memAddr <= BaseAddrW + ADDR_W'(w_idx) + ADDR_W'(1);
                            r_state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!i_abort && r_loopQ) begin
                        r_memAddr <= BaseAddrW;
                        r_state   <= FETCH;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_memAddr;
    assign bus.bit_out   = r_bitOut;
    assign bus.bit_valid = r_bitValid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_onesCount   = w_ones;

endmodule

// File: tb/tb_pattern_reader.sv
// tb_pattern_reader
// Self-checking bench for pattern_reader. A ROM array models the pattern,
// and the expected stream is derived from it by plain arithmetic.
module tb_pattern_reader;
    import pattern_pkg::*;

    localparam int ADDR_W = 1024;
    localparam int LEN_W  = 8;
    localparam int BASE   = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] lenIn;
    logic             loopIn;
    logic             abort;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] onesCount;

    logic rom [0:255];

    int checks = 0;
    int errors = 0;

    pattern_if #(.ADDR_W(ADDR_W)) bus ();

    // Combinational ROM; addresses outside the table read 0.
    assign bus.mem_data = (bus.mem_addr < ADDR_W'(256)) ? rom[bus.mem_addr[7:0]] : 1'b0;

    pattern_reader #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .BASE_ADDR(BASE)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_len      (lenIn),
        .i_loop     (loopIn),
        .i_abort    (abort),
        .bus        (bus.master),
        .o_busy     (busy),
        .o_done     (done),
        .o_onesCount(onesCount)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Runs one start..end sequence. Expected bit k is rom[BASE + k%len] at
    // address BASE + k%len; a done pulse follows each pass-ending accept.
    task automatic applyStimulus(input int len, input bit lp, input int passes, input int stall,
                                 input int abortAt, input bit midStart, output int onesModel);
        int   k = 0;
        int   t = 0;
        int   passModel = 0;
        int   doneSeen = 0;
        int   stallLeft = 0;
        int   expOnes = 0;
        bit   firstSeen = 0;
        bit   doneExp = 0;
        bit   prevValid = 0;
        bit   prevAcc = 0;
        bit   prevBit = 0;
        bit   stopping = 0;
        bit   finished = 0;
        bit   rdy;
        logic [63:0] prevAddr = '0;

        @(negedge clk);
        checkOutput("idle_busy_before_start", busy, 0);
        start  = 1'b1;
        lenIn  = LEN_W'(len);
        loopIn = lp;
        abort  = 1'b0;
        while (!finished && t < 3000) begin
            @(negedge clk);
            t++;
            start  = midStart && (t == 3);
            lenIn  = LEN_W'($urandom);
            loopIn = 1'($urandom);
            abort  = 1'b0;
            if (stopping) begin
                checkOutput("end_busy", busy, 0);
                checkOutput("end_valid", bus.bit_valid, 0);
                checkOutput("end_done", done, 0);
                checkOutput("end_addr", bus.mem_addr[63:0], 0);
                finished = 1'b1;
            end else begin
                checkOutput("done_pulse", done, doneExp);
                if (done) doneSeen++;
                if (prevAcc) checkOutput("valid_after_accept", bus.bit_valid, 0);
                if (doneExp) begin
                    passModel++;
                    if (!lp) begin
                        stopping = 1'b1;
                    end else if (passModel == passes) begin
                        abort    = 1'b1;
                        stopping = 1'b1;
                    end
                end
                doneExp = 1'b0;
                rdy = 1'b0;
                if (bus.bit_valid) begin
                    if (!firstSeen) begin
                        firstSeen = 1'b1;
                        checkOutput("first_valid_latency", 64'(t), 2);
                    end
                    checkOutput("bit_out", bus.bit_out, rom[BASE + k % len]);
                    checkOutput("mem_addr", bus.mem_addr[63:0], 64'(BASE + k % len));
                    if (prevValid && !prevAcc) begin
                        checkOutput("hold_bit", bus.bit_out, prevBit);
                        checkOutput("hold_addr", bus.mem_addr[63:0], prevAddr);
                    end else begin
                        stallLeft = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                    end
                    if (stallLeft > 0) begin
                        stallLeft--;
                    end else begin
                        rdy = 1'b1;
                    end
                    if (rdy && !stopping) begin
                        if (rom[BASE + k % len]) expOnes++;
                        if (k % len == len - 1) doneExp = 1'b1;
                        if (abortAt >= 0 && k == abortAt) begin
                            abort    = 1'b1;
                            doneExp  = 1'b0;
                            stopping = 1'b1;
                        end
                        k++;
                    end
                end else begin
                    rdy = 1'($urandom);
                end
                bus.bit_ready = rdy;
                prevAcc   = bus.bit_valid && rdy;
                prevValid = bus.bit_valid;
                prevBit   = bus.bit_out;
                prevAddr  = bus.mem_addr[63:0];
            end
        end
        if (!finished) checkOutput("run_timeout", 1, 0);
        start  = 1'b0;
        abort  = 1'b0;
        checkOutput("ones_count", onesCount, 64'(expOnes % 256));
        checkOutput("done_pulses", 64'(doneSeen), (abortAt >= 0) ? 0 : 64'(passes));
        onesModel = expOnes;
    endtask

    initial begin
        int ones;
        int basicBits [21] = '{1,0,0,0,1,1,0,0,0,1,0,1,1,0,1,0,0,0,1,0,0};
        bit gotValid;

        for (int i = 0; i < 256; i++) rom[i] = 1'b0;
        for (int i = 0; i < 21; i++) rom[i + 1] = 1'(basicBits[i]);

        reset = 1'b1;
        start = 1'b0;
        lenIn = '0;
        loopIn = 1'b0;
        abort = 1'b0;
        bus.bit_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_valid", bus.bit_valid, 0);
        checkOutput("reset_bit", bus.bit_out, 0);
        checkOutput("reset_addr", bus.mem_addr[63:0], 0);
        checkOutput("reset_ones", onesCount, 0);
        reset = 1'b0;

        // Basic run, no backpressure.
        applyStimulus(21, 0, 1, 0, -1, 0, ones);
        checkOutput("basic_ones", onesCount, 8);

        // Backpressure: three stalled cycles per bit.
        applyStimulus(5, 0, 1, 3, -1, 0, ones);
        checkOutput("backpressure_ones", onesCount, 2);

        // Loop mode, three passes.
        applyStimulus(3, 1, 3, 0, -1, 0, ones);
        checkOutput("loop_ones", onesCount, 3);

        // Abort coincident with the accept of bit 6.
        applyStimulus(21, 0, 1, 0, 5, 0, ones);
        checkOutput("abort_ones", onesCount, 3);

        // Zero length start: done only, ones cleared.
        @(negedge clk);
        start = 1'b1;
        lenIn = '0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_len_done", done, 1);
        checkOutput("zero_len_busy", busy, 0);
        checkOutput("zero_len_valid", bus.bit_valid, 0);
        checkOutput("zero_len_ones", onesCount, 0);
        @(negedge clk);
        checkOutput("zero_len_done_clear", done, 0);

        // Start asserted mid-run is ignored.
        applyStimulus(4, 0, 1, 0, -1, 1, ones);
        checkOutput("ignored_start_ones", onesCount, 1);

        // Randomised pattern contents and runs.
        for (int i = 1; i < 256; i++) rom[i] = 1'($urandom);
        applyStimulus(255, 0, 1, 0, -1, 0, ones);
        for (int r = 0; r < 8; r++) begin
            int  l;
            bit  lp;
            int  ab;
            l  = int'($urandom_range(1, 30));
            lp = 1'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, l - 1)) : -1;
            applyStimulus(l, lp, lp ? int'($urandom_range(1, 3)) : 1, -1, ab, 1'($urandom), ones);
        end

        // Asynchronous reset while holding a bit.
        for (int i = 0; i < 21; i++) rom[i + 1] = 1'(basicBits[i]);
        @(negedge clk);
        bus.bit_ready = 1'b0;
        start  = 1'b1;
        lenIn  = 8'd21;
        loopIn = 1'b0;
        gotValid = 1'b0;
        for (int c = 0; c < 10 && !gotValid; c++) begin
            @(negedge clk);
            start = 1'b0;
            gotValid = bus.bit_valid;
        end
        checkOutput("areset_reached_hold", gotValid, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_busy", busy, 0);
        checkOutput("areset_valid", bus.bit_valid, 0);
        checkOutput("areset_bit", bus.bit_out, 0);
        checkOutput("areset_addr", bus.mem_addr[63:0], 0);
        checkOutput("areset_done", done, 0);
        checkOutput("areset_ones", onesCount, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
